// File: rtl/ccip_tx_pkg.sv
// rtl/ccip_tx_pkg.sv - shared types and helpers for the CCI-P flow transmit engine
// Holds the CCI-P c1 request types, the payload type, the engine state enum,
// the flow id type and the batch-size to beat-count / cl_len mapping.
// Optional feature macro: CCIP_TX_FLUSH_TIMEOUT_EN adds the TxFlush state.
package ccip_tx_pkg;

    localparam int LMAX_CCIP_BATCH = 2;
    localparam int FLOW_ID_W       = 8;

    typedef logic [FLOW_ID_W-1:0] FlowId;
    typedef logic [41:0]          t_ccip_clAddr;
    typedef logic [63:0]          RpcIf;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4
    } t_ccip_c1_req;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        t_ccip_clAddr address;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
    typedef enum logic [1:0] {TxIdle, TxBurst, TxFlush} TxState;
`else
    typedef enum logic [0:0] {TxIdle, TxBurst} TxState;
`endif

    // Beats per batch: 1, 2 or 4 for l = 0..2.
    function automatic logic [2:0] batch_beats(input logic [LMAX_CCIP_BATCH-1:0] l);
        return 3'd1 << l;
    endfunction

    function automatic t_ccip_clLen batch_cl_len(input logic [LMAX_CCIP_BATCH-1:0] l);
        case (l)
            2'd0:    return eCL_LEN_1;
            2'd1:    return eCL_LEN_2;
            default: return eCL_LEN_4;
        endcase
    endfunction

endpackage

// File: rtl/ccip_flow_tx_engine_if.sv
// rtl/ccip_flow_tx_engine_if.sv - ingress payload and CCI-P c1 channel bundle
// master: payload source and c1 backpressure driver; slave: the engine.
// Signals: rpc_in/rpc_in_valid/rpc_flow_id_in (ingress), sRx_c1TxAlmFull,
// sTx_c1 (write request), ccip_tx_ready.
interface ccip_flow_tx_engine_if #(
    parameter int LMAX_NUM_OF_FLOWS = 2
);
    import ccip_tx_pkg::*;

    RpcIf                         rpc_in;
    logic                         rpc_in_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in;
    logic                         sRx_c1TxAlmFull;
    t_if_ccip_c1_Tx               sTx_c1;
    logic                         ccip_tx_ready;

    modport master (
        output rpc_in, rpc_in_valid, rpc_flow_id_in, sRx_c1TxAlmFull,
        input  sTx_c1, ccip_tx_ready
    );

    modport slave (
        input  rpc_in, rpc_in_valid, rpc_flow_id_in, sRx_c1TxAlmFull,
        output sTx_c1, ccip_tx_ready
    );
endinterface

// File: rtl/ccip_tx_flow_fifo.sv
// rtl/ccip_tx_flow_fifo.sv - per-flow single-clock payload FIFO
// Ports: clk, reset (async active-high), push/push_data, pop, pop_data
// (registered, valid the cycle after pop), count (occupancy).
// The caller guarantees no pop when empty and no push when full unless it
// pops in the same cycle.
module ccip_tx_flow_fifo
    import ccip_tx_pkg::*;
#(
    parameter int LDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  RpcIf          push_data,
    input  logic          pop,
    output RpcIf          pop_data,
    output logic [LDEPTH:0] count
);
    localparam int DEPTH = 2**LDEPTH;

    RpcIf              mem [DEPTH];
    logic [LDEPTH-1:0] wr_ptr;
    logic [LDEPTH-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ccip_flow_tx_engine.sv
// rtl/ccip_flow_tx_engine.sv - batches per-flow payloads into CCI-P c1 line writes
// Ports: clk, reset (async active-high), number_of_flows, tx_base_addr,
// l_tx_batch_size, start, bus (slave: ingress payload, c1 request, backpressure),
// drop_cnt (saturating ingress drop count).
// Optional macro CCIP_TX_FLUSH_TIMEOUT_EN: partial batches idle for
// FLUSH_CYCLES are flushed as single-line writes.
module ccip_flow_tx_engine
    import ccip_tx_pkg::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 2,
    parameter int LFIFO_DEPTH       = 4,
    parameter int FLUSH_CYCLES      = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 tx_base_addr,
    input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
    input  logic                         start,
    ccip_flow_tx_engine_if.slave         bus,
    output logic [31:0]                  drop_cnt
);
    localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
    localparam int CNT_W     = LFIFO_DEPTH + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(2**LFIFO_DEPTH);

    // NIC_ID only tags debug output; a negative index has no meaning.
    if (NIC_ID < 0) begin : g_nic_id_invalid
    end

    logic [MAX_FLOWS-1:0] push;
    logic [MAX_FLOWS-1:0] pop;
    logic [CNT_W-1:0]     count    [MAX_FLOWS];
    RpcIf                 pop_data [MAX_FLOWS];

    for (genvar f = 0; f < MAX_FLOWS; f++) begin : g_fifo
        ccip_tx_flow_fifo #(.LDEPTH(LFIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[f]),
            .push_data (bus.rpc_in),
            .pop       (pop[f]),
            .pop_data  (pop_data[f]),
            .count     (count[f])
        );
    end

    TxState                       state;
    FlowId                        ptr;
    FlowId                        cur_flow;
    logic [LMAX_NUM_OF_FLOWS-1:0] nof_q;
    logic [LMAX_CCIP_BATCH-1:0]   l_q;
    t_ccip_clAddr                 burst_addr;
    logic [CNT_W-1:0]             beat;
    logic [CNT_W-1:0]             last_beat;
    logic                         tx_valid;
    t_ccip_c1_ReqMemHdr           tx_hdr;

    logic             in_fire;
    logic             in_accept;
    logic             in_flush;
    logic [CNT_W-1:0] batch_live;
    logic [CNT_W-1:0] exam_count;

    function automatic FlowId next_flow(input FlowId p, input FlowId last);
        return (p >= last) ? '0 : p + 1'b1;
    endfunction

    assign batch_live = CNT_W'(batch_beats(l_tx_batch_size));
    assign exam_count = count[ptr[LMAX_NUM_OF_FLOWS-1:0]];

    // A full FIFO still accepts a beat when it is being popped this cycle.
    always_comb begin
        in_fire   = start && bus.rpc_in_valid;
        in_accept = in_fire && (bus.rpc_flow_id_in <= number_of_flows) &&
                    ((count[bus.rpc_flow_id_in] != FULL) || pop[bus.rpc_flow_id_in]);
        push = '0;
        if (in_accept) push[bus.rpc_flow_id_in] = 1'b1;
    end

    always_comb begin
        pop = '0;
        if (state != TxIdle) pop[cur_flow[LMAX_NUM_OF_FLOWS-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (in_fire && !in_accept && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
    localparam int AGE_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FLUSH_CYCLES);

    logic [AGE_W-1:0] age [MAX_FLOWS];

    // Age only counts while a flow holds a partial batch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < MAX_FLOWS; f++) age[f] <= '0;
        end else begin
            for (int f = 0; f < MAX_FLOWS; f++) begin
                if (pop[f] || count[f] == '0) age[f] <= '0;
                else if (count[f] < batch_live && age[f] != AGE_MAX) age[f] <= age[f] + 1'b1;
            end
        end
    end

    assign in_flush = (state == TxFlush);
`else
    if (FLUSH_CYCLES < 1) begin : g_flush_cycles_invalid
    end

    assign in_flush = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= TxIdle;
            ptr        <= '0;
            cur_flow   <= '0;
            nof_q      <= '0;
            l_q        <= '0;
            burst_addr <= '0;
            beat       <= '0;
            last_beat  <= '0;
            tx_valid   <= 1'b0;
            tx_hdr     <= '0;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                TxIdle: begin
                    beat <= '0;
                    if (!bus.sRx_c1TxAlmFull && exam_count >= batch_live) begin
                        state      <= TxBurst;
                        cur_flow   <= ptr;
                        nof_q      <= number_of_flows;
                        l_q        <= l_tx_batch_size;
                        burst_addr <= tx_base_addr + (t_ccip_clAddr'(ptr) << l_tx_batch_size);
                        last_beat  <= batch_live - 1'b1;
                    end
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
                    else if (!bus.sRx_c1TxAlmFull && age[ptr[LMAX_NUM_OF_FLOWS-1:0]] == AGE_MAX) begin
                        state      <= TxFlush;
                        cur_flow   <= ptr;
                        nof_q      <= number_of_flows;
                        l_q        <= l_tx_batch_size;
                        burst_addr <= tx_base_addr + (t_ccip_clAddr'(ptr) << l_tx_batch_size);
                        last_beat  <= exam_count - 1'b1;
                    end
`endif
                    else begin
                        ptr <= next_flow(ptr, FlowId'(number_of_flows));
                    end
                end
                default: begin
                    // Burst or flush: one pop per cycle, backpressure ignored once started.
                    tx_valid        <= 1'b1;
                    tx_hdr.vc_sel   <= eVC_VH0;
                    tx_hdr.req_type <= eREQ_WRLINE_I;
                    tx_hdr.sop      <= in_flush || (beat == '0);
                    tx_hdr.cl_len   <= in_flush ? eCL_LEN_1 : batch_cl_len(l_q);
                    tx_hdr.address  <= burst_addr + t_ccip_clAddr'(beat);
                    beat            <= beat + 1'b1;
                    if (beat == last_beat) begin
                        state <= TxIdle;
                        ptr   <= next_flow(cur_flow, FlowId'(nof_q));
                    end
                end
            endcase
        end
    end

    // Data comes straight from the FIFO's registered read port, aligned with tx_valid.
    t_if_ccip_c1_Tx tx_out;
    always_comb begin
        tx_out       = '0;
        tx_out.valid = tx_valid;
        tx_out.hdr   = tx_hdr;
        tx_out.data[$bits(RpcIf)-1:0] = pop_data[cur_flow[LMAX_NUM_OF_FLOWS-1:0]];
    end

    assign bus.sTx_c1        = tx_out;
    assign bus.ccip_tx_ready = ~bus.sRx_c1TxAlmFull;
endmodule

// File: tb/tb_ccip_flow_tx_engine.sv
// tb/tb_ccip_flow_tx_engine.sv - scoreboard bench for ccip_flow_tx_engine
module tb_ccip_flow_tx_engine;
    import ccip_tx_pkg::*;

    localparam int LMAX = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [LMAX-1:0]      number_of_flows;
    t_ccip_clAddr         tx_base_addr;
    logic [1:0]           l_tx_batch_size;
    logic                 start;
    logic [31:0]          drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    ccip_flow_tx_engine_if #(.LMAX_NUM_OF_FLOWS(LMAX)) bus ();

    ccip_flow_tx_engine #(
        .NIC_ID(0), .LMAX_NUM_OF_FLOWS(LMAX), .LFIFO_DEPTH(4), .FLUSH_CYCLES(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .number_of_flows (number_of_flows),
        .tx_base_addr    (tx_base_addr),
        .l_tx_batch_size (l_tx_batch_size),
        .start           (start),
        .bus             (bus.slave),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        t_ccip_clAddr addr;
        t_ccip_clLen  len;
        logic         sop;
        RpcIf         data;
    } exp_t;

    exp_t exp_q[$];
    int   runs[$];
    int   run_len = 0;
    int   valid_count = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            run_len = 0;
        end else if (bus.sTx_c1.valid) begin
            valid_count++;
            run_len++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_beat: got addr=%h data=%h, required no beat",
                         bus.sTx_c1.hdr.address, bus.sTx_c1.data[63:0]);
            end else begin
                e = exp_q.pop_front();
                if (bus.sTx_c1.hdr.address !== e.addr || bus.sTx_c1.hdr.cl_len !== e.len ||
                    bus.sTx_c1.hdr.sop !== e.sop || bus.sTx_c1.data[63:0] !== e.data ||
                    bus.sTx_c1.hdr.req_type !== eREQ_WRLINE_I || bus.sTx_c1.hdr.vc_sel !== eVC_VH0) begin
                    tests_failed++;
                    $display("FAIL beat: got addr=%h len=%0d sop=%0b data=%h req=%0d vc=%0d, required addr=%h len=%0d sop=%0b data=%h req=0 vc=2",
                             bus.sTx_c1.hdr.address, bus.sTx_c1.hdr.cl_len, bus.sTx_c1.hdr.sop,
                             bus.sTx_c1.data[63:0], bus.sTx_c1.hdr.req_type, bus.sTx_c1.hdr.vc_sel,
                             e.addr, e.len, e.sop, e.data);
                end
            end
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.rpc_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        runs.delete();
    endtask

    task automatic send(input logic [LMAX-1:0] flow, input RpcIf d);
        bus.rpc_flow_id_in = flow;
        bus.rpc_in = d;
        bus.rpc_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rpc_in_valid = 1'b0;
    endtask

    task automatic expect_beat(input t_ccip_clAddr a, input t_ccip_clLen l, input logic s, input RpcIf d);
        exp_t e;
        e.addr = a; e.len = l; e.sop = s; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, output int left);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        left = exp_q.size();
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (bus.sTx_c1.valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int vc0;
        do_reset();
        @(negedge clk);
        tests_run++;
        if (bus.sTx_c1.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", bus.sTx_c1.valid); end
        tests_run++;
        if (drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
        tests_run++;
        if (bus.ccip_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_low_almfull: got %b, required 1", bus.ccip_tx_ready); end
        bus.sRx_c1TxAlmFull = 1'b1;
        #1;
        tests_run++;
        if (bus.ccip_tx_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_high_almfull: got %b, required 0", bus.ccip_tx_ready); end
        bus.sRx_c1TxAlmFull = 1'b0;
        // Ingress is ignored while start is low: no push and no drop.
        l_tx_batch_size = 2'd0;
        start = 1'b0;
        vc0 = valid_count;
        send(2'd0, 64'hDEAD_0000_0000_0001);
        send(2'd3, 64'hDEAD_0000_0000_0002);
        repeat (20) @(posedge clk);
        start = 1'b1;
        tests_run++;
        if (valid_count - vc0 !== 0) begin tests_failed++; $display("FAIL start_gate_beats: got %0d, required 0", valid_count - vc0); end
        tests_run++;
        if (drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL start_gate_drops: got %0d, required 0", drop_cnt); end
    endtask

    task automatic test_batch_l1();
        int left;
        RpcIf d;
        do_reset();
        l_tx_batch_size = 2'd1;
        number_of_flows = 2'd3;
        tx_base_addr = 42'h1000;
        for (int i = 0; i < 4; i++) begin
            d = 64'hB100_0000_0000_0000 + 64'(i);
            expect_beat(42'h1004 + 42'(i % 2), eCL_LEN_2, (i % 2) == 0, d);
            send(2'd2, d);
        end
        wait_drain(100, left);
        tests_run++;
        if (left !== 0) begin tests_failed++; $display("FAIL l1_drain: got %0d pending, required 0", left); end
        tests_run++;
        if (runs.size() !== 2) begin
            tests_failed++; $display("FAIL l1_runs: got %0d bursts, required 2", runs.size());
        end else if (runs[0] !== 2 || runs[1] !== 2) begin
            tests_failed++; $display("FAIL l1_run_len: got %0d/%0d, required 2/2", runs[0], runs[1]);
        end
    endtask

    task automatic test_overflow();
        int left, vc0;
        RpcIf d;
        do_reset();
        l_tx_batch_size = 2'd2;
        number_of_flows = 2'd3;
        tx_base_addr = 42'h2000;
        bus.sRx_c1TxAlmFull = 1'b1;
        vc0 = valid_count;
        for (int i = 0; i < 17; i++) begin
            d = 64'hC000_0000_0000_0000 + 64'(i);
            if (i < 16) expect_beat(42'h2000 + 42'(i % 4), eCL_LEN_4, (i % 4) == 0, d);
            send(2'd0, d);
        end
        repeat (20) @(posedge clk);
        tests_run++;
        if (drop_cnt !== 32'd1) begin tests_failed++; $display("FAIL overflow_drop_cnt: got %0d, required 1", drop_cnt); end
        tests_run++;
        if (valid_count - vc0 !== 0) begin tests_failed++; $display("FAIL almfull_hold_beats: got %0d, required 0", valid_count - vc0); end
        bus.sRx_c1TxAlmFull = 1'b0;
        wait_drain(200, left);
        tests_run++;
        if (left !== 0) begin tests_failed++; $display("FAIL overflow_drain: got %0d pending, required 0", left); end
        tests_run++;
        if (valid_count - vc0 !== 16) begin tests_failed++; $display("FAIL overflow_beats: got %0d, required 16", valid_count - vc0); end
    endtask

    task automatic test_two_flows();
        int left;
        RpcIf d;
        do_reset();
        l_tx_batch_size = 2'd2;
        number_of_flows = 2'd3;
        tx_base_addr = 42'h3000;
        for (int i = 0; i < 4; i++) begin
            d = 64'hF000_0000_0000_0000 + 64'(i);
            expect_beat(42'h3000 + 42'(i), eCL_LEN_4, i == 0, d);
            send(2'd0, d);
        end
        for (int i = 0; i < 4; i++) begin
            d = 64'hF300_0000_0000_0000 + 64'(i);
            expect_beat(42'h300C + 42'(i), eCL_LEN_4, i == 0, d);
            send(2'd3, d);
        end
        wait_drain(100, left);
        tests_run++;
        if (left !== 0) begin tests_failed++; $display("FAIL two_flows_drain: got %0d pending, required 0", left); end
        tests_run++;
        if (runs.size() !== 2) begin
            tests_failed++; $display("FAIL two_flows_runs: got %0d bursts, required 2", runs.size());
        end else if (runs[0] !== 4 || runs[1] !== 4) begin
            tests_failed++; $display("FAIL two_flows_run_len: got %0d/%0d, required 4/4", runs[0], runs[1]);
        end
    endtask

    task automatic test_almfull_mid();
        int left, vc0;
        bit seen;
        RpcIf d;
        do_reset();
        l_tx_batch_size = 2'd2;
        number_of_flows = 2'd3;
        tx_base_addr = 42'h5000;
        vc0 = valid_count;
        for (int i = 0; i < 4; i++) begin
            d = 64'hA100_0000_0000_0000 + 64'(i);
            expect_beat(42'h5004 + 42'(i), eCL_LEN_4, i == 0, d);
            send(2'd1, d);
        end
        wait_valid(50, seen);
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL almfull_mid_start: got no beat, required a burst"); end
        bus.sRx_c1TxAlmFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'hA200_0000_0000_0000 + 64'(i);
            expect_beat(42'h5004 + 42'(i), eCL_LEN_4, i == 0, d);
            send(2'd1, d);
        end
        repeat (40) @(posedge clk);
        tests_run++;
        if (valid_count - vc0 !== 4) begin tests_failed++; $display("FAIL almfull_mid_beats: got %0d, required 4", valid_count - vc0); end
        tests_run++;
        if (runs.size() < 1 || runs[0] !== 4) begin tests_failed++; $display("FAIL almfull_mid_run: got %0d runs, required first run of 4", runs.size()); end
        bus.sRx_c1TxAlmFull = 1'b0;
        wait_drain(100, left);
        tests_run++;
        if (left !== 0 || valid_count - vc0 !== 8) begin
            tests_failed++; $display("FAIL almfull_release: got %0d beats %0d pending, required 8 beats 0 pending", valid_count - vc0, left);
        end
    endtask

    task automatic test_flush();
        int vc0;
        RpcIf d;
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
        int left;
`endif
        do_reset();
        l_tx_batch_size = 2'd2;
        number_of_flows = 2'd3;
        tx_base_addr = 42'h6000;
        vc0 = valid_count;
        for (int i = 0; i < 3; i++) begin
            d = 64'hE000_0000_0000_0000 + 64'(i);
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
            expect_beat(42'h6004 + 42'(i), eCL_LEN_1, 1'b1, d);
`endif
            send(2'd1, d);
        end
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
        wait_drain(100, left);
        tests_run++;
        if (left !== 0 || valid_count - vc0 !== 3) begin
            tests_failed++; $display("FAIL flush_beats: got %0d beats %0d pending, required 3 beats 0 pending", valid_count - vc0, left);
        end
`else
        repeat (100) @(posedge clk);
        tests_run++;
        if (valid_count - vc0 !== 0) begin tests_failed++; $display("FAIL partial_wait: got %0d beats, required 0", valid_count - vc0); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int vc0;
        bit seen;
        RpcIf d;
        do_reset();
        l_tx_batch_size = 2'd2;
        number_of_flows = 2'd1;
        tx_base_addr = 42'h7000;
        send(2'd3, 64'h1111_2222_3333_4444);
        tests_run++;
        if (drop_cnt !== 32'd1) begin tests_failed++; $display("FAIL range_drop_cnt: got %0d, required 1", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            d = 64'h7700_0000_0000_0000 + 64'(i);
            expect_beat(42'h7000 + 42'(i), eCL_LEN_4, i == 0, d);
            send(2'd0, d);
        end
        wait_valid(50, seen);
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_start: got no beat, required a burst"); end
        reset = 1'b1;
        l_tx_batch_size = 2'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.sTx_c1.valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b, required 0", bus.sTx_c1.valid); end
        tests_run++;
        if (drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_drop_cnt: got %0d, required 0", drop_cnt); end
        reset = 1'b0;
        exp_q.delete();
        vc0 = valid_count;
        repeat (30) @(posedge clk);
        tests_run++;
        if (valid_count - vc0 !== 0) begin tests_failed++; $display("FAIL rst_mid_counts_cleared: got %0d beats, required 0", valid_count - vc0); end
    endtask

    initial begin
        start = 1'b1;
        number_of_flows = 2'd3;
        tx_base_addr = '0;
        l_tx_batch_size = 2'd0;
        bus.rpc_in = '0;
        bus.rpc_in_valid = 1'b0;
        bus.rpc_flow_id_in = '0;
        bus.sRx_c1TxAlmFull = 1'b0;
        test_reset();
        test_batch_l1();
        test_overflow();
        test_two_flows();
        test_almfull_mid();
        test_flush();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
